// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC timestamp decoder:
//   - default delay-line length (NCARRY4_DEFAULT) and coarse counter width
//   - FSM state encoding
//   - thermometer encoding helpers (population count, first-zero priority)
// The helpers work on a fixed TAPS_MAX-wide vector; callers zero-extend their
// tap vector, which conveniently makes "no zero found" return the real tap
// count for the priority encoder.
// -----------------------------------------------------------------------------
package tdc_pkg;

  localparam int NCARRY4_DEFAULT  = 2;
  localparam int COARSE_W_DEFAULT = 16;

  // Widest delay line the helper functions support (16 CARRY4 stages).
  localparam int TAPS_MAX = 64;
  localparam int CODE_W   = 7;  // enough to hold TAPS_MAX

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2,
    REARM   = 2'd3
  } tdc_state_e;

  // Number of ones in the tap vector; tolerant of bubbles in the code.
  function automatic logic [CODE_W-1:0] thermo_popcount(input logic [TAPS_MAX-1:0] t);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < TAPS_MAX; i++) begin
      r = r + CODE_W'(t[i]);
    end
    return r;
  endfunction

  // Index of the first 0 counting from bit 0.
  function automatic logic [CODE_W-1:0] thermo_first_zero(input logic [TAPS_MAX-1:0] t);
    logic [CODE_W-1:0] r;
    logic              found;
    r     = CODE_W'(TAPS_MAX);
    found = 1'b0;
    for (int i = 0; i < TAPS_MAX; i++) begin
      if (!found && !t[i]) begin
        r     = CODE_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder.sv
// -----------------------------------------------------------------------------
// tdc_thermo_encoder
// Combinational fine-code encoder for the synchronised delay-line taps.
// Build option: define TDC_BUBBLE_FILTER_EN to count ones (bubble tolerant);
// otherwise the code is the position of the first 0 from bit 0 (NTAPS if the
// hit ran through every tap). Clean thermometer codes give the same result.
// Ports:
//   taps  in   NTAPS   synchronised tap vector
//   fine  out  FINE_W  number of taps the hit propagated through
//   ovf   out  1       hit propagated through all taps
// -----------------------------------------------------------------------------
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter int NTAPS  = 8,
  parameter int FINE_W = $clog2(NTAPS + 1)
) (
  input  logic [NTAPS-1:0]  taps,
  output logic [FINE_W-1:0] fine,
  output logic              ovf
);

  logic [TAPS_MAX-1:0] taps_ext;

  assign taps_ext = TAPS_MAX'(taps);

`ifdef TDC_BUBBLE_FILTER_EN
  assign fine = FINE_W'(thermo_popcount(taps_ext));
`else
  assign fine = FINE_W'(thermo_first_zero(taps_ext));
`endif

  assign ovf = &taps;

endmodule

// File: rtl/tdc_timestamp_decoder.sv
// -----------------------------------------------------------------------------
// tdc_timestamp_decoder
// Turns the raw CARRY4 thermometer of a tapped delay line into timestamps
// (coarse clk count + fine tap count) with a valid/ready handshake.
// Build option: TDC_BUBBLE_FILTER_EN selects the bubble-tolerant fine encoder.
// Ports:
//   clk        in   1         sampling clock
//   rst        in   1         asynchronous active-high reset
//   enable     in   1         arms the decoder
//   taps       in   NTAPS     raw delay-line taps (asynchronous to clk)
//   ts_ready   in   1         consumer accepts timestamp
//   ts_valid   out  1         timestamp available
//   ts_coarse  out  COARSE_W  coarse count of the cycle the edge was sampled
//   ts_fine    out  FINE_W    taps propagated at hit
//   ts_ovf     out  1         hit propagated through all taps
//   lost_hit   out  1         sticky: hit arrived while a timestamp pending
// -----------------------------------------------------------------------------
module tdc_timestamp_decoder
  import tdc_pkg::*;
#(
  parameter int NCARRY4  = NCARRY4_DEFAULT,
  parameter int COARSE_W = COARSE_W_DEFAULT,
  localparam int NTAPS   = 4 * NCARRY4,
  localparam int FINE_W  = $clog2(NTAPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NTAPS-1:0]    taps,
  input  logic                ts_ready,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_ovf,
  output logic                lost_hit
);

  logic [NTAPS-1:0]    s1_reg;
  logic [NTAPS-1:0]    s2_reg;
  logic                tap0_prev_reg;
  logic [COARSE_W-1:0] cnt_reg;
  tdc_state_e          state_reg, state_next;
  logic                capture;
  logic                hit;
  logic [COARSE_W-1:0] ts_coarse_reg;
  logic [FINE_W-1:0]   ts_fine_reg;
  logic                ts_ovf_reg;
  logic                lost_hit_reg;
  logic                enable_prev_reg;
  logic [FINE_W-1:0]   fine_code;
  logic                ovf_code;

  // Two-flop synchroniser; only S2 is ever decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg        <= '0;
      s2_reg        <= '0;
      tap0_prev_reg <= 1'b0;
    end else begin
      s1_reg        <= taps;
      s2_reg        <= s1_reg;
      tap0_prev_reg <= s2_reg[0];
    end
  end

  // Free-running coarse counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_reg + COARSE_W'(1);
  end

  assign hit = s2_reg[0] & ~tap0_prev_reg;

  tdc_thermo_encoder #(
    .NTAPS  (NTAPS),
    .FINE_W (FINE_W)
  ) u_encoder (
    .taps (s2_reg),
    .fine (fine_code),
    .ovf  (ovf_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A pending timestamp survives enable dropping; it leaves only on handshake.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (hit) begin
          state_next = PENDING;
          capture    = 1'b1;
        end
      end
      PENDING: begin
        if (ts_ready) state_next = enable ? REARM : IDLE;
      end
      REARM: begin
        // Wait for the trigger to fall so a held-high input cannot re-fire.
        if (!enable)         state_next = IDLE;
        else if (!s2_reg[0]) state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  // The hit is visible one cycle after S1 sampled it, so the counter is one
  // ahead of the sample cycle at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_coarse_reg <= '0;
      ts_fine_reg   <= '0;
      ts_ovf_reg    <= 1'b0;
    end else if (capture) begin
      ts_coarse_reg <= cnt_reg - COARSE_W'(1);
      ts_fine_reg   <= fine_code;
      ts_ovf_reg    <= ovf_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_hit_reg    <= 1'b0;
      enable_prev_reg <= 1'b0;
    end else begin
      enable_prev_reg <= enable;
      if (enable_prev_reg && !enable)
        lost_hit_reg <= 1'b0;
      else if (state_reg == PENDING && hit)
        lost_hit_reg <= 1'b1;
    end
  end

  assign ts_valid  = (state_reg == PENDING);
  assign ts_coarse = ts_coarse_reg;
  assign ts_fine   = ts_fine_reg;
  assign ts_ovf    = ts_ovf_reg;
  assign lost_hit  = lost_hit_reg;

endmodule

// File: doc/tdc_timestamp_decoder.md
TDC_TIMESTAMP_DECODER -- requirements
Module: tdc_timestamp_decoder

Interface
REQ-001 SHALL have parameter NCARRY4, default 2, number of cascaded CARRY4 stages in the delay line feeding this block.
REQ-002 SHALL have parameter COARSE_W, default 16, coarse counter width in clk cycles.
REQ-003 SHALL derive local constants NTAPS = 4*NCARRY4 and FINE_W = $clog2(NTAPS+1).
REQ-004 clk  input  1  100 MHz sampling clock; one clock domain only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  arms the decoder when high.
REQ-007 taps  input  NTAPS  raw CO thermometer from delay line, asynchronous to clk.
REQ-008 ts_ready  input  1  consumer accepts timestamp.
REQ-009 ts_valid  output  1  timestamp available.
REQ-010 ts_coarse  output  COARSE_W  coarse count at hit.
REQ-011 ts_fine  output  FINE_W  number of taps propagated at hit.
REQ-012 ts_ovf  output  1  hit propagated through all NTAPS taps.
REQ-013 lost_hit  output  1  sticky: a hit arrived while a timestamp was pending.

Function
REQ-014 SHALL register taps in stage S1, then re-register into S2 (metastability); decoding uses S2 only.
REQ-015 SHALL run a free-running coarse counter, +1 every clk, wrapping 2^COARSE_W-1 -> 0, independent of enable.
REQ-016 Hit = S2 tap[0] is 1 while the previous S2 tap[0] was 0.
REQ-017 SHALL implement FSM states IDLE, ARMED, PENDING, REARM.
REQ-018 IDLE -> ARMED when enable=1; any state except PENDING -> IDLE when enable=0.
REQ-019 ARMED -> PENDING on hit; capture coarse counter value of the S1 sample cycle (counter minus 1, modulo wrap) and fine code.
REQ-020 PENDING: ts_valid=1, outputs stable; on ts_valid & ts_ready -> REARM (or IDLE if enable=0).
REQ-021 REARM -> ARMED once S2 tap[0]=0; a held-high trigger SHALL NOT produce a second timestamp.
REQ-022 A hit detected while in PENDING SHALL set lost_hit and SHALL NOT alter pending outputs.
REQ-023 Latency: taps edge sampled in cycle n -> ts_valid high in cycle n+3.
REQ-024 ts_ready high when ts_valid=0 SHALL have no effect; ts_valid SHALL NOT drop without a handshake.
REQ-025 All taps = 1 at hit: ts_fine = NTAPS, ts_ovf = 1; otherwise ts_ovf = 0.
REQ-026 lost_hit clears only on reset or on enable falling edge.

Reset
REQ-027 On rst: FSM IDLE, coarse counter 0, S1/S2 zero, ts_valid 0, ts_coarse 0, ts_fine 0, ts_ovf 0, lost_hit 0.
REQ-028 rst asserted mid-PENDING SHALL discard the pending timestamp immediately.

Configuration
REQ-029 Macro TDC_BUBBLE_FILTER_EN defined: ts_fine = population count of S2 taps (bubble tolerant).
REQ-030 Macro TDC_BUBBLE_FILTER_EN undefined: ts_fine = index of first 0 in S2 taps from bit 0 (priority encoder), NTAPS if none.
REQ-031 Both variants SHALL give identical results for clean thermometer codes.

Structure
REQ-032 Shared package tdc_pkg SHALL hold FSM state encoding, default NCARRY4 and COARSE_W, and the popcount/priority-encode functions.
REQ-033 Fine encoder SHALL be a sub-module tdc_thermo_encoder (S2 taps in, fine code and ovf out, combinational, macro-selected).

Verification
REQ-034 enable=1, taps 0x00 -> 0x0F at coarse=40, ts_ready=1 -> ts_valid pulse 3 cycles later, ts_fine=4, ts_coarse=40, ts_ovf=0.
REQ-035 taps 0x00 -> 0xFF -> ts_fine=8, ts_ovf=1.
REQ-036 taps 0x00 -> 0x0B (bubble) -> ts_fine=3 with TDC_BUBBLE_FILTER_EN, 2 without.
REQ-037 ts_ready=0, two hits 20 cycles apart -> first timestamp held, lost_hit=1; after ts_ready=1, one timestamp only.
REQ-038 taps held 0xFF for 500 ns then 0x00 then 0x07 -> exactly two timestamps, second ts_fine=3.
REQ-039 rst pulse while ts_valid=1 -> ts_valid=0 asynchronously, all outputs at reset values; coarse wraps 0xFFFF -> 0x0000 with correct capture.
